// File: rtl/mac_pkg.sv
// Shared definitions for the streaming multiply-accumulate engine.
//   mac_state_t : frame FSM states (IDLE, ACCUM, DRAIN, HOLD)
//   MAC_IN_W    : default operand width
//   MAC_DEPTH   : default products per frame
//   acc_width() : accumulator width that cannot overflow for a full frame
//   cnt_width() : width of a beat counter able to hold the value DEPTH
package mac_pkg;

    localparam int MAC_IN_W  = 4;
    localparam int MAC_DEPTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } mac_state_t;

    // 2*in_w bits per product plus one bit per doubling of the frame length.
    function automatic int acc_width(input int in_w, input int depth);
        return 2 * in_w + $clog2(depth);
    endfunction

    // out_count must represent 1..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered IN_W x IN_W multiplier, first stage of the MAC pipeline.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : operands are a real beat
//   in_a/in_b : operands (unsigned, or two's complement when SIGNED != 0)
//   out_valid : out_prod holds the product of a beat accepted one cycle earlier
//   out_prod  : 2*IN_W-bit product (two's complement when SIGNED != 0)
module mac_mult_stage #(
    parameter int IN_W   = 4,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [IN_W-1:0]     in_a,
    input  logic [IN_W-1:0]     in_b,
    output logic                out_valid,
    output logic [2*IN_W-1:0]   out_prod
);

    localparam int PW = 2 * IN_W;

    logic [PW-1:0] prod_comb;

    // Operands are widened to the full product width before multiplying so
    // the product is exact; the signed variant sign-extends them first.
    generate
        if (SIGNED != 0) begin : g_signed
            assign prod_comb = PW'($signed(in_a)) * PW'($signed(in_b));
        end else begin : g_unsigned
            assign prod_comb = PW'(in_a) * PW'(in_b);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_prod  <= '0;
        end else begin
            out_valid <= in_valid;
            // Only capture real beats; the register otherwise holds still.
            if (in_valid) begin
                out_prod <= prod_comb;
            end
        end
    end

endmodule

// File: rtl/mac_stream_accum.sv
// Streaming multiply-accumulate engine. Accepts one operand pair per cycle
// over valid/ready, accumulates up to DEPTH products per frame (a frame can
// close early with in_last) and presents one registered dot-product result
// per frame over valid/ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand beat handshake
//   in_a, in_b          : operands
//   in_last             : marks the final beat of a short frame
//   out_valid/out_ready : result handshake; result held until accepted
//   out_sum             : frame result (ACC_W bits)
//   out_ovf             : an accumulate overflowed during the frame
//   out_count           : beats in the frame (1..DEPTH)
// Build option: define MAC_SATURATE_EN to clamp the accumulator on overflow
// (it then stays clamped for the rest of the frame); without it the
// accumulator wraps modulo 2^ACC_W. out_ovf reports the event either way.
module mac_stream_accum
    import mac_pkg::*;
#(
    parameter int IN_W   = MAC_IN_W,
    parameter int DEPTH  = MAC_DEPTH,
    parameter int ACC_W  = acc_width(IN_W, DEPTH),
    parameter int SIGNED = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_W-1:0]             in_a,
    input  logic [IN_W-1:0]             in_b,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_sum,
    output logic                        out_ovf,
    output logic [cnt_width(DEPTH)-1:0] out_count
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PW    = 2 * IN_W;

    mac_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   count_reg;
    logic               drain_reg;
    logic               ready_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               ovf_reg;
    logic               out_valid_reg;
    logic [ACC_W-1:0]   out_sum_reg;
    logic               out_ovf_reg;
    logic [CNT_W-1:0]   out_count_reg;

    logic               beat;
    logic               last_beat;
    logic               result_taken;
    logic               prod_valid;
    logic [PW-1:0]      prod;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W:0]     sum_wide;
    logic               add_ovf;

    assign beat         = in_valid & ready_reg;
    // Count still holds the number of earlier beats, so DEPTH-1 marks beat DEPTH.
    assign last_beat    = beat & (in_last | (count_reg == CNT_W'(DEPTH - 1)));
    assign result_taken = (state_reg == HOLD) & out_ready;

    // ---------------- stage 1: registered multiply ----------------
    mac_mult_stage #(
        .IN_W   (IN_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (beat),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (prod_valid),
        .out_prod  (prod)
    );

    // ---------------- stage 2: extend and add ----------------
    generate
        if (SIGNED != 0) begin : g_sext
            assign prod_ext = ACC_W'($signed(prod));
        end else begin : g_zext
            assign prod_ext = ACC_W'(prod);
        end
    endgenerate

    assign sum_wide = {1'b0, acc_reg} + {1'b0, prod_ext};

    // Unsigned: carry out. Signed: both addends share a sign the result lacks.
    always_comb begin
        add_ovf = 1'b0;
        if (SIGNED != 0) begin
            add_ovf = (acc_reg[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_wide[ACC_W-1] != acc_reg[ACC_W-1]);
        end else begin
            add_ovf = sum_wide[ACC_W];
        end
    end

`ifdef MAC_SATURATE_EN
    logic [ACC_W-1:0] sat_val;

    // A signed overflow always has the direction of the accumulator's sign.
    always_comb begin
        sat_val = '1;
        if (SIGNED != 0) begin
            sat_val = acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`endif

    // ---------------- frame FSM ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (beat) state_next = last_beat ? DRAIN : ACCUM;
            ACCUM:   if (last_beat) state_next = DRAIN;
            // Two cycles: one for the multiplier, one for the final add.
            DRAIN:   if (drain_reg) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- datapath and control registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            drain_reg     <= 1'b0;
            ready_reg     <= 1'b0;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_ovf_reg   <= 1'b0;
            out_count_reg <= '0;
        end else begin
            // Registered ready follows the state being entered.
            ready_reg <= (state_next == IDLE) || (state_next == ACCUM);
            drain_reg <= (state_reg == DRAIN) ? ~drain_reg : 1'b0;

            if (result_taken) begin
                count_reg <= '0;
            end else if (beat) begin
                count_reg <= count_reg + CNT_W'(1);
            end

            if (result_taken) begin
                acc_reg <= '0;
                ovf_reg <= 1'b0;
            end else if (prod_valid) begin
`ifdef MAC_SATURATE_EN
                // Once clamped the accumulator ignores further products.
                if (!ovf_reg) begin
                    if (add_ovf) begin
                        acc_reg <= sat_val;
                        ovf_reg <= 1'b1;
                    end else begin
                        acc_reg <= sum_wide[ACC_W-1:0];
                    end
                end
`else
                acc_reg <= sum_wide[ACC_W-1:0];
                ovf_reg <= ovf_reg | add_ovf;
`endif
            end

            // The final add lands on the first DRAIN edge, so the second
            // DRAIN edge captures the complete frame result.
            if ((state_reg == DRAIN) && drain_reg) begin
                out_valid_reg <= 1'b1;
                out_sum_reg   <= acc_reg;
                out_ovf_reg   <= ovf_reg;
                out_count_reg <= count_reg;
            end else if (result_taken) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign in_ready  = ready_reg;
    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_ovf   = out_ovf_reg;
    assign out_count = out_count_reg;

endmodule
